subtract_feeder32: RTL and testbench
====================================

Name: subtract_feeder32

Overview:
- Transmit side of the subtract datapath: sequences point groups into the PE_ROW-lane subtract stage.
- Accepts a point stream from the grouping buffer on a valid/ready handshake; each group is one centroid beat followed by NUM_NEIGHBOR neighbor beats.
- Drives the receiver's centroid/neighbor strobes and data with the timing the receiver requires: centroid strobe for 1 cycle, each neighbor held for NEIGHBOR_HOLD cycles.
- Counts the receiver's done pulses to report group completion.

Parameters:
- INPUT_DATA_WIDTH, 8, bits per lane
- PE_ROW, 16, lanes per beat
- NUM_NEIGHBOR, 16, neighbor beats per group (≥1)
- NEIGHBOR_HOLD, 4, cycles is_neighbor stays high per neighbor; matches the receiver's 2-bit counter latching on the 4th consecutive cycle

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  upstream beat valid
- s_ready  out  1  feeder can accept a beat
- s_data  in  INPUT_DATA_WIDTH*PE_ROW  upstream point, lane i at [W*i +: W]
- is_centroid  out  1  centroid load strobe to the subtract stage
- is_neighbor  out  1  neighbor strobe to the subtract stage
- dout_centroid  out  INPUT_DATA_WIDTH*PE_ROW  centroid vector
- dout_neighbor  out  INPUT_DATA_WIDTH*PE_ROW  neighbor vector
- sub_done  in  1  done pulse from the subtract stage
- group_done  out  1  1-cycle pulse: group fully issued (and acknowledged if the feature is on)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; s_ready=0 during reset, then 1 in IDLE; is_centroid=0, is_neighbor=0, dout_*=0, group_done=0, busy=0; all counters=0. Reset mid-group abandons the group with no group_done.
- All outputs are registered; a handshake occurs when s_valid&&s_ready.
- FSM states: IDLE, CENT, NB_WAIT, NB_HOLD, DRAIN.
- IDLE: s_ready=1. On handshake: dout_centroid<=s_data, go to CENT.
- CENT: is_centroid=1 for exactly this 1 cycle; s_ready=0; nb_cnt=0; then go to NB_WAIT.
- NB_WAIT: s_ready=1, is_neighbor=0. On handshake: dout_neighbor<=s_data, hold_cnt=0, go to NB_HOLD.
- NB_HOLD: is_neighbor=1 and s_ready=0; dout_neighbor stable. hold_cnt increments each cycle. When hold_cnt==NEIGHBOR_HOLD-1:
  - if nb_cnt==NUM_NEIGHBOR-1, go to DRAIN;
  - else nb_cnt++ and go to NB_WAIT.
- Neighbor bursts are therefore separated by at least 1 low cycle of is_neighbor.
- DRAIN: s_ready=0. Exit as defined under Optional Feature; emits group_done for 1 cycle, then goes to IDLE.
- Throughput: minimum 2 + NUM_NEIGHBOR*(NEIGHBOR_HOLD+1) + 1 cycles per group with s_valid held high.
- s_valid low in IDLE or NB_WAIT: the FSM waits indefinitely; outputs hold, strobes stay 0.
- dout_centroid changes only on an IDLE handshake; dout_neighbor changes only on an NB_WAIT handshake.
- Counter widths: nb_cnt $clog2(NUM_NEIGHBOR)+1, hold_cnt $clog2(NEIGHBOR_HOLD)+1; neither wraps inside a group.

Optional Feature:
- Macro: SUBTRACT_FEEDER_ACK_CHECK_EN.
- Defined:
  - ack_cnt counts sub_done pulses while busy; it is cleared on CENT.
  - DRAIN waits until ack_cnt==NUM_NEIGHBOR, then pulses group_done.
  - Adds output ack_error (1 bit, reset 0, sticky until rstn). It sets when sub_done arrives in IDLE, or when ack_cnt would exceed NUM_NEIGHBOR.
- Undefined:
  - sub_done is ignored and ack_error is not present.
  - DRAIN lasts 1 cycle; group_done pulses on the cycle after the last hold cycle.

Decomposition:
- Package subtract_feeder_pkg holds:
  - state enum localparams (IDLE=0, CENT=1, NB_WAIT=2, NB_HOLD=3, DRAIN=4), 3-bit state width;
  - default NEIGHBOR_HOLD=4 constant, shared with the receiver side.
- One sub-module: feeder_hold_counter (load/enable/terminal-count counter). It is used for both hold_cnt and nb_cnt.

Test Plan:
- Reset, then a group with NUM_NEIGHBOR=2 and lanes = lane index: is_centroid high 1 cycle with dout_centroid=0x0F0E…00; each neighbor gives is_neighbor high exactly 4 cycles; group_done pulses once.
- s_valid toggled 1-0-1 in NB_WAIT: is_neighbor stays 0 during gaps; dout_neighbor unchanged until the next handshake.
- Back-to-back groups with s_valid always 1: s_ready waveform is 1,0,1,0000,1,0000,0 repeating; second is_centroid follows the first group_done+1 cycle.
- rstn pulsed low on 2nd cycle of NB_HOLD: all outputs 0 asynchronously, no group_done; next group is issued cleanly from IDLE.
- With ACK_CHECK_EN, a loopback receiver model asserts sub_done 1 cycle after each 4th hold cycle: group_done follows the 2nd sub_done; a withheld sub_done keeps the FSM in DRAIN.
- With ACK_CHECK_EN, sub_done injected in IDLE: ack_error=1 and stays 1 until reset.

Source files
------------

// File: rtl/subtract_feeder_pkg.sv
// Shared definitions for the subtract feeder: state encodings and the hold-length default
// that the receiver side must also agree on.
package subtract_feeder_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] CENT    = 3'd1;
    localparam logic [STATE_W-1:0] NB_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] NB_HOLD = 3'd3;
    localparam logic [STATE_W-1:0] DRAIN   = 3'd4;

    // The receiver's 2-bit counter latches a neighbor on its 4th consecutive strobe cycle.
    localparam int unsigned DEFAULT_NEIGHBOR_HOLD = 4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/subtract_feeder32_hold_counter.sv
// Load/enable counter with a terminal-count flag; used for both the per-neighbor hold
// length and the neighbor index within a group.
module feeder_hold_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned TERMINAL = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/subtract_feeder32.sv
// Transmit-side sequencer for the subtract stage: one centroid strobe then NUM_NEIGHBOR held
// neighbor strobes per group. Define SUBTRACT_FEEDER_ACK_CHECK_EN to gate group_done on sub_done acks.
module subtract_feeder32
    import subtract_feeder_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH = 8,
    parameter int unsigned PE_ROW           = 16,
    parameter int unsigned NUM_NEIGHBOR     = 16,
    parameter int unsigned NEIGHBOR_HOLD    = DEFAULT_NEIGHBOR_HOLD
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [INPUT_DATA_WIDTH*PE_ROW-1:0] s_data,
    output logic                               is_centroid,
    output logic                               is_neighbor,
    output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] dout_centroid,
    output logic [INPUT_DATA_WIDTH*PE_ROW-1:0] dout_neighbor,
    input  logic                               sub_done,
    output logic                               group_done,
    output logic                               busy
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
    ,
    output logic                               ack_error
`endif
);

    localparam int unsigned NB_W   = cnt_width(NUM_NEIGHBOR);
    localparam int unsigned HOLD_W = cnt_width(NEIGHBOR_HOLD);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_d;
    logic               hs;
    logic               hold_tc;
    logic               nb_tc;
    logic               drain_ok;
    logic               gd_next;

    assign hs = s_valid && s_ready;

    feeder_hold_counter #(
        .WIDTH    (HOLD_W),
        .TERMINAL (NEIGHBOR_HOLD - 1)
    ) u_hold_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load ((state == NB_WAIT) && hs),
        .en   (state == NB_HOLD),
        .tc   (hold_tc)
    );

    feeder_hold_counter #(
        .WIDTH    (NB_W),
        .TERMINAL (NUM_NEIGHBOR - 1)
    ) u_nb_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (state == CENT),
        .en   ((state == NB_HOLD) && hold_tc && !nb_tc),
        .tc   (nb_tc)
    );

`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
    localparam logic [NB_W-1:0] ACK_FULL = NB_W'(NUM_NEIGHBOR);

    logic [NB_W-1:0] ack_cnt;
    logic [NB_W-1:0] ack_cnt_d;
    logic            ack_error_d;

    always_comb begin
        ack_cnt_d   = ack_cnt;
        ack_error_d = ack_error;
        if (state == CENT) begin
            ack_cnt_d = '0;
        end else if (sub_done) begin
            if (state == IDLE || ack_cnt == ACK_FULL) begin
                ack_error_d = 1'b1;
            end else begin
                ack_cnt_d = ack_cnt + NB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_cnt   <= '0;
            ack_error <= 1'b0;
        end else begin
            ack_cnt   <= ack_cnt_d;
            ack_error <= ack_error_d;
        end
    end

    // group_done is registered, so it is qualified with the ack count DRAIN will see next cycle.
    assign drain_ok = (ack_cnt == ACK_FULL);
    assign gd_next  = (ack_cnt_d == ACK_FULL);
`else
    logic sub_done_unused;

    assign sub_done_unused = sub_done;
    assign drain_ok        = 1'b1;
    assign gd_next         = 1'b1;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs) state_d = CENT;
            CENT:    state_d = NB_WAIT;
            NB_WAIT: if (hs) state_d = NB_HOLD;
            NB_HOLD: if (hold_tc) state_d = nb_tc ? DRAIN : NB_WAIT;
            DRAIN:   if (drain_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered strobe lines up with its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            s_ready       <= 1'b0;
            is_centroid   <= 1'b0;
            is_neighbor   <= 1'b0;
            group_done    <= 1'b0;
            busy          <= 1'b0;
            dout_centroid <= '0;
            dout_neighbor <= '0;
        end else begin
            state       <= state_d;
            s_ready     <= (state_d == IDLE) || (state_d == NB_WAIT);
            is_centroid <= (state_d == CENT);
            is_neighbor <= (state_d == NB_HOLD);
            group_done  <= (state_d == DRAIN) && gd_next;
            busy        <= (state_d != IDLE);
            if ((state == IDLE) && hs) begin
                dout_centroid <= s_data;
            end
            if ((state == NB_WAIT) && hs) begin
                dout_neighbor <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_subtract_feeder32.sv
// Self-checking bench for subtract_feeder32: a segment-level timeline model predicts every
// output for every cycle of randomized group traffic.
module tb_subtract_feeder32;

    localparam int unsigned W  = 8;
    localparam int unsigned PR = 16;
    localparam int unsigned NN = 2;
    localparam int unsigned NH = 4;
    localparam int unsigned DW = W * PR;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          is_centroid;
    logic          is_neighbor;
    logic [DW-1:0] dout_centroid;
    logic [DW-1:0] dout_neighbor;
    logic          sub_done = 1'b0;
    logic          group_done;
    logic          busy;
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
    logic          ack_error;
`endif

    always #5 clk = ~clk;

    subtract_feeder32 #(
        .INPUT_DATA_WIDTH (W),
        .PE_ROW           (PR),
        .NUM_NEIGHBOR     (NN),
        .NEIGHBOR_HOLD    (NH)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .is_centroid   (is_centroid),
        .is_neighbor   (is_neighbor),
        .dout_centroid (dout_centroid),
        .dout_neighbor (dout_neighbor),
        .sub_done      (sub_done),
        .group_done    (group_done),
        .busy          (busy)
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
        ,
        .ack_error     (ack_error)
`endif
    );

    // One entry per clock cycle: inputs to drive and outputs expected during that cycle.
    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sdone;
        logic          rdy;
        logic          ic;
        logic          nb;
        logic          gd;
        logic          bsy;
        logic [DW-1:0] dc;
        logic [DW-1:0] dn;
        logic          aerr;
    } cyc_t;

    cyc_t          q[$];
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] m_c = '0;
    logic [DW-1:0] m_n = '0;
    logic          m_err = 1'b0;
    logic          pend = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(DW / 32); i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(PR); i++) r[W*i +: W] = W'(i);
        return r;
    endfunction

    task automatic push(input logic sv, input logic [DW-1:0] sd, input logic sdx,
                        input logic rdy, input logic ic, input logic nb,
                        input logic gd, input logic bsy);
        cyc_t e;
        e.sv = sv; e.sd = sd; e.sdone = sdx | pend; pend = 1'b0;
        e.rdy = rdy; e.ic = ic; e.nb = nb; e.gd = gd; e.bsy = bsy;
        e.dc = m_c; e.dn = m_n; e.aerr = m_err;
        q.push_back(e);
    endtask

    // Group timeline: idle gap, centroid accept, 1 strobe cycle, then per neighbor a wait gap,
    // accept, NH strobe cycles; a loopback receiver acks the cycle after each hold burst.
    task automatic add_group(input int unsigned maxgap, input bit lanes, input int unsigned drain_delay);
        logic [DW-1:0] d;
        repeat ($urandom_range(maxgap)) push(0, rnd_beat(), 0, 1, 0, 0, 0, 0);
        d = lanes ? lane_beat() : rnd_beat();
        push(1, d, 0, 1, 0, 0, 0, 0);
        m_c = d;
        push(0, rnd_beat(), 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < int'(NN); k++) begin
            repeat ($urandom_range(maxgap)) push(0, rnd_beat(), 0, 1, 0, 0, 0, 1);
            d = rnd_beat();
            push(1, d, 0, 1, 0, 0, 0, 1);
            m_n = d;
            repeat (NH) push(0, rnd_beat(), 0, 0, 0, 1, 0, 1);
            pend = 1'b1;
        end
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
        if (drain_delay > 0) begin
            pend = 1'b0;
            repeat (drain_delay) push(0, rnd_beat(), 0, 0, 0, 0, 0, 1);
        end
        push(0, rnd_beat(), drain_delay > 0, 0, 0, 0, 0, 1);
        push(0, rnd_beat(), 0, 0, 0, 0, 1, 1);
`else
        if (drain_delay > 0) pend = 1'b1;
        push(0, rnd_beat(), 0, 0, 0, 0, 1, 1);
`endif
    endtask

    task automatic run(input int n);
        cyc_t e;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            e = q.pop_front();
            check1("s_ready", s_ready, e.rdy);
            check1("is_centroid", is_centroid, e.ic);
            check1("is_neighbor", is_neighbor, e.nb);
            check1("group_done", group_done, e.gd);
            check1("busy", busy, e.bsy);
            checkw("dout_centroid", dout_centroid, e.dc);
            checkw("dout_neighbor", dout_neighbor, e.dn);
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
            check1("ack_error", ack_error, e.aerr);
`endif
            s_valid  = e.sv;
            s_data   = e.sd;
            sub_done = e.sdone;
            @(negedge clk);
        end
    endtask

    // Called at a negedge; asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset(input string tag);
        #1;
        rstn     = 1'b0;
        s_valid  = 1'b0;
        sub_done = 1'b0;
        #1;
        check1({tag, "_s_ready"}, s_ready, 1'b0);
        check1({tag, "_is_centroid"}, is_centroid, 1'b0);
        check1({tag, "_is_neighbor"}, is_neighbor, 1'b0);
        check1({tag, "_group_done"}, group_done, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        checkw({tag, "_dout_centroid"}, dout_centroid, '0);
        checkw({tag, "_dout_neighbor"}, dout_neighbor, '0);
`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
        check1({tag, "_ack_error"}, ack_error, 1'b0);
`endif
        repeat (2) @(negedge clk);
        check1({tag, "_group_done_held"}, group_done, 1'b0);
        rstn  = 1'b1;
        q.delete();
        m_c   = '0;
        m_n   = '0;
        m_err = 1'b0;
        pend  = 1'b0;
        push(0, rnd_beat(), 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset("reset");
        add_group(0, 1'b1, 0);
        run(1000);
        checkw("lane_centroid", dout_centroid, 128'h0F0E0D0C0B0A09080706050403020100);

        add_group(3, 1'b0, 0);
        add_group(3, 1'b0, 0);
        run(1000);

        repeat (3) add_group(0, 1'b0, 0);
        run(1000);

        repeat (4) add_group(2, 1'b0, 0);
        run(1000);

        add_group(0, 1'b0, 0);
        run(4);
        check1("midhold_strobe_before_reset", is_neighbor, 1'b1);
        do_reset("midhold");
        add_group(1, 1'b0, 0);
        run(1000);

`ifdef SUBTRACT_FEEDER_ACK_CHECK_EN
        add_group(0, 1'b0, 3);
        add_group(1, 1'b0, 0);
        run(1000);

        push(0, rnd_beat(), 1, 1, 0, 0, 0, 0);
        m_err = 1'b1;
        add_group(1, 1'b0, 0);
        run(1000);
        do_reset("ackerr_clear");
        add_group(0, 1'b0, 0);
        run(1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
